img_sram_tx_streamer: RTL

Reads a stored image out of an img_sram instance and streams it as a byte sequence on a valid/ready output port. It is the transmit counterpart to the RX path that fills SRAM from the byte input. It sits between the image SRAM port mux and the host-facing dout path. It supports row-major or column-major traversal, so either the original or the transposed image can be emitted.

---
 rtl/img_sram_tx_streamer_pkg.sv | 16 +
 rtl/img_sram_tx_streamer_if.sv | 34 +++
 rtl/img_sram_tx_streamer_fifo.sv | 50 +++++
 rtl/img_sram_tx_streamer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/img_sram_tx_streamer_pkg.sv
// Shared types and helpers for the image SRAM transmit streamer.
package img_conv_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_READ,
      TX_DRAIN,
      TX_FINISH
   } tx_state_t;

   // Smallest skid FIFO that can absorb every read in flight plus one held byte.
   function automatic int tx_fifo_depth_min(input int read_lat);
      return read_lat + 1;
   endfunction

endpackage

// File: rtl/img_sram_tx_streamer_if.sv
// Control, SRAM read port and byte stream of the transmit streamer.
interface img_sram_tx_streamer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] nrows;
   logic [ADDR_W-1:0] ncols;
   logic              col_major;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] sram_row;
   logic [ADDR_W-1:0] sram_col;
   logic              sram_sense_en;
   logic              sram_write_en;
   logic [DATA_W-1:0] sram_din;
   logic [DATA_W-1:0] sram_dout;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              dout_last;

   modport master (
      input  start, nrows, ncols, col_major, sram_dout, dout_ready,
      output busy, done, sram_row, sram_col, sram_sense_en, sram_write_en,
             sram_din, dout, dout_valid, dout_last
   );

   modport slave (
      output start, nrows, ncols, col_major, sram_dout, dout_ready,
      input  busy, done, sram_row, sram_col, sram_sense_en, sram_write_en,
             sram_din, dout, dout_valid, dout_last
   );
endinterface

// File: rtl/img_sram_tx_streamer_fifo.sv
// Small synchronous skid FIFO; push and pop may coincide, including when full.
module img_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
         end
         if (do_pop)
            rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/img_sram_tx_streamer.sv
// Streams a stored image out of SRAM as bytes, row- or column-major,
// with credit-based read issue into a skid FIFO.
module img_sram_tx_streamer
   import img_conv_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int READ_LAT   = 1,
   parameter int FIFO_DEPTH = 2
) (
   input logic                    clk,
   input logic                    rst,
   img_sram_tx_streamer_if.master bus
);
   localparam int TX_FIFO_DEPTH_MIN = tx_fifo_depth_min(READ_LAT);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int IW = $clog2(READ_LAT + 2);
   localparam int RW = 2 * ADDR_W;

   if (FIFO_DEPTH < TX_FIFO_DEPTH_MIN) begin : g_depth_chk
      $error("img_sram_tx_streamer: FIFO_DEPTH must be >= READ_LAT+1");
   end

   tx_state_t         state;
   logic [ADDR_W-1:0] nrows_q, ncols_q, row_q, col_q;
   logic              cm_q;
   logic [RW-1:0]     remain_q;
   logic [IW-1:0]     infl_q;
   logic [READ_LAT-1:0] rd_pipe;

   logic [CW-1:0]     fifo_cnt;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_rdata;
   logic              push, pop, credit_ok, issue;
   logic              row_end, col_end, last_addr;

   assign pop       = !fifo_empty && bus.dout_ready;
   assign push      = rd_pipe[READ_LAT-1];
   // A slot popped this cycle is already free for a new read.
   assign credit_ok = (int'(fifo_cnt) + int'(infl_q) - int'(pop)) < FIFO_DEPTH;
   assign issue     = (state == TX_READ) && credit_ok;
   assign row_end   = (row_q == nrows_q - ADDR_W'(1));
   assign col_end   = (col_q == ncols_q - ADDR_W'(1));
   assign last_addr = row_end && col_end;

   assign bus.busy          = (state == TX_READ) || (state == TX_DRAIN);
   assign bus.done          = (state == TX_FINISH);
   assign bus.sram_row      = row_q;
   assign bus.sram_col      = col_q;
   assign bus.sram_sense_en = issue;
   assign bus.sram_write_en = 1'b0;
   assign bus.sram_din      = '0;
   assign bus.dout_valid    = !fifo_empty;
   assign bus.dout          = fifo_empty ? '0 : fifo_rdata;
   assign bus.dout_last     = !fifo_empty && (remain_q == RW'(1));

   // Transfer FSM with parameter latch and address walk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= TX_IDLE;
         nrows_q <= '0;
         ncols_q <= '0;
         cm_q    <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         case (state)
            TX_IDLE: if (bus.start) begin
               nrows_q <= bus.nrows;
               ncols_q <= bus.ncols;
               cm_q    <= bus.col_major;
               row_q   <= '0;
               col_q   <= '0;
               state   <= (bus.nrows == '0 || bus.ncols == '0) ? TX_FINISH : TX_READ;
            end
            TX_READ: if (issue) begin
               if (last_addr) begin
                  row_q <= '0;
                  col_q <= '0;
                  state <= TX_DRAIN;
               end else if (!cm_q) begin
                  if (col_end) begin
                     col_q <= '0;
                     row_q <= row_q + ADDR_W'(1);
                  end else begin
                     col_q <= col_q + ADDR_W'(1);
                  end
               end else begin
                  if (row_end) begin
                     row_q <= '0;
                     col_q <= col_q + ADDR_W'(1);
                  end else begin
                     row_q <= row_q + ADDR_W'(1);
                  end
               end
            end
            TX_DRAIN: if (pop && remain_q == RW'(1)) state <= TX_FINISH;
            default:  state <= TX_IDLE;
         endcase
      end
   end

   // Remaining-byte counter that marks the final byte of the image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         remain_q <= '0;
      else if (state == TX_IDLE && bus.start)
         remain_q <= RW'(bus.nrows) * RW'(bus.ncols);
      else if (pop)
         remain_q <= remain_q - RW'(1);
   end

   // Read-return delay line and in-flight read count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pipe <= '0;
         infl_q  <= '0;
      end else begin
         rd_pipe[0] <= issue;
         for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         case ({issue, push})
            2'b10:   infl_q <= infl_q + IW'(1);
            2'b01:   infl_q <= infl_q - IW'(1);
            default: infl_q <= infl_q;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && fifo_full && !pop));

   img_tx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (bus.sram_dout),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );
endmodule
